// File: rtl/sram_rd_scheduler.sv
// Read-side sequencer for one SRAM bank: round-robin packet arbitration, page-chain walk,
// slice reads and page return. Optional chain bank check under `SRAM_RD_BANK_CHECK_EN.
module sram_rd_scheduler #(
    parameter int PORT_NUM = 16,
    parameter int PORT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            SRAM_IDX,
    input  logic [PORT_NUM-1:0]   rd_req,
    input  logic [PORT_NUM*11-1:0] rd_head_page,
    input  logic [PORT_NUM*6-1:0] rd_page_num,
    input  logic [PORT_NUM*3-1:0] rd_last_len,
    output logic [PORT_NUM-1:0]   rd_grant,
    output logic                  rd_busy,
    output logic                  sram_rd_en,
    output logic [13:0]           sram_rd_addr,
    output logic [10:0]           jt_rd_addr,
    input  logic [15:0]           jt_dout,
    output logic                  np_ret_vld,
    output logic [10:0]           np_ret_page,
    output logic                  out_vld,
    output logic [PORT_W-1:0]     out_port,
    output logic                  out_last,
    output logic                  rd_done,
    output logic                  rd_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [PORT_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [10:0]       cur_page, cur_page_nxt, next_page, next_page_nxt;
    logic [2:0]        slice, slice_nxt, last_len, last_len_nxt;
    logic [5:0]        pages_left, pages_left_nxt;

    logic [PORT_NUM-1:0] grant_nxt;
    logic                rd_en_nxt, ret_vld_nxt, out_vld_nxt, out_last_nxt, rd_done_nxt, rd_err_nxt;
    logic [13:0]         rd_addr_nxt;
    logic [10:0]         jt_addr_nxt, ret_page_nxt;
    logic [PORT_W-1:0]   out_port_nxt;

    logic              win_found;
    logic [PORT_W-1:0] win, idx;
    logic              issue;
    logic [10:0]       iss_page;
    logic [2:0]        iss_slice;
    logic [5:0]        iss_left, req_pn;

`ifndef SRAM_RD_BANK_CHECK_EN
    logic unused_bank;
    assign unused_bank = ^{SRAM_IDX, jt_dout[15:11]};
`endif

    assign rd_busy = (state != IDLE);

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        idx       = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            idx = rr_ptr + PORT_W'(i);
            if (!win_found && rd_req[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        cur_page_nxt   = cur_page;
        next_page_nxt  = next_page;
        slice_nxt      = slice;
        last_len_nxt   = last_len;
        pages_left_nxt = pages_left;
        grant_nxt      = '0;
        rd_en_nxt      = 1'b0;
        rd_addr_nxt    = sram_rd_addr;
        jt_addr_nxt    = jt_rd_addr;
        ret_vld_nxt    = 1'b0;
        ret_page_nxt   = np_ret_page;
        out_vld_nxt    = sram_rd_en;
        out_port_nxt   = out_port;
        out_last_nxt   = 1'b0;
        rd_done_nxt    = 1'b0;
        rd_err_nxt     = 1'b0;
        issue          = 1'b0;
        iss_page       = cur_page;
        iss_slice      = slice;
        iss_left       = pages_left;
        req_pn         = rd_page_num[int'(win)*6 +: 6];

        case (state)
            IDLE: begin
                if (win_found) begin
                    issue          = 1'b1;
                    iss_page       = rd_head_page[int'(win)*11 +: 11];
                    iss_slice      = 3'd0;
                    iss_left       = (req_pn == 6'd0) ? 6'd1 : req_pn;
                    last_len_nxt   = rd_last_len[int'(win)*3 +: 3];
                    grant_nxt[win] = 1'b1;
                    out_port_nxt   = win;
                    rr_ptr_nxt     = win + 1'b1;
                end
            end
            READ: begin
                issue = 1'b1;
                if (slice == 3'd7) begin
                    iss_page  = next_page;
                    iss_slice = 3'd0;
                    iss_left  = pages_left - 6'd1;
                end else begin
                    iss_slice = slice + 3'd1;
                end
            end
            DRAIN: begin
                out_last_nxt = 1'b1;
                rd_done_nxt  = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (issue) begin
            rd_en_nxt      = 1'b1;
            rd_addr_nxt    = {iss_page, iss_slice};
            cur_page_nxt   = iss_page;
            slice_nxt      = iss_slice;
            pages_left_nxt = iss_left;
            state_nxt      = READ;
            if (iss_slice == 3'd0)
                jt_addr_nxt = iss_page;
            // Page is returned alongside its last slice read.
            if (iss_left == 6'd1 && iss_slice == last_len_nxt) begin
                ret_vld_nxt  = 1'b1;
                ret_page_nxt = iss_page;
                state_nxt    = DRAIN;
            end else if (iss_slice == 3'd7) begin
                ret_vld_nxt  = 1'b1;
                ret_page_nxt = iss_page;
            end
        end

        // jt_dout answers the slice-0 lookup while slice 1 is on the bus.
        if (state == READ && slice == 3'd1 && pages_left != 6'd1) begin
            next_page_nxt = jt_dout[10:0];
`ifdef SRAM_RD_BANK_CHECK_EN
            if (jt_dout[15:11] != SRAM_IDX) begin
                rd_err_nxt     = 1'b1;
                pages_left_nxt = 6'd1;
                last_len_nxt   = 3'd7;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_page     <= '0;
            next_page    <= '0;
            slice        <= '0;
            last_len     <= '0;
            pages_left   <= '0;
            rd_grant     <= '0;
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            jt_rd_addr   <= '0;
            np_ret_vld   <= 1'b0;
            np_ret_page  <= '0;
            out_vld      <= 1'b0;
            out_port     <= '0;
            out_last     <= 1'b0;
            rd_done      <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            cur_page     <= cur_page_nxt;
            next_page    <= next_page_nxt;
            slice        <= slice_nxt;
            last_len     <= last_len_nxt;
            pages_left   <= pages_left_nxt;
            rd_grant     <= grant_nxt;
            sram_rd_en   <= rd_en_nxt;
            sram_rd_addr <= rd_addr_nxt;
            jt_rd_addr   <= jt_addr_nxt;
            np_ret_vld   <= ret_vld_nxt;
            np_ret_page  <= ret_page_nxt;
            out_vld      <= out_vld_nxt;
            out_port     <= out_port_nxt;
            out_last     <= out_last_nxt;
            rd_done      <= rd_done_nxt;
            rd_err       <= rd_err_nxt;
        end
    end

endmodule

// File: tb/tb_sram_rd_scheduler.sv
// Bench for sram_rd_scheduler: per-packet cycle script built from the packet rules,
// compared every cycle, plus directed cases with literal expectations.
module tb_sram_rd_scheduler;
    localparam int PN = 16;
    localparam int PW = 4;
    localparam logic [4:0] BANK = 5'd2;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic [4:0]      SRAM_IDX = BANK;
    logic [PN-1:0]   rd_req = '0;
    logic [PN*11-1:0] rd_head_page = '0;
    logic [PN*6-1:0] rd_page_num = '0;
    logic [PN*3-1:0] rd_last_len = '0;
    logic [PN-1:0]   rd_grant;
    logic            rd_busy, sram_rd_en, np_ret_vld, out_vld, out_last, rd_done, rd_err;
    logic [13:0]     sram_rd_addr;
    logic [10:0]     jt_rd_addr, np_ret_page;
    logic [15:0]     jt_dout = '0;
    logic [PW-1:0]   out_port;

    sram_rd_scheduler #(.PORT_NUM(PN), .PORT_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .SRAM_IDX(SRAM_IDX), .rd_req(rd_req),
        .rd_head_page(rd_head_page), .rd_page_num(rd_page_num), .rd_last_len(rd_last_len),
        .rd_grant(rd_grant), .rd_busy(rd_busy), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
        .jt_rd_addr(jt_rd_addr), .jt_dout(jt_dout), .np_ret_vld(np_ret_vld), .np_ret_page(np_ret_page),
        .out_vld(out_vld), .out_port(out_port), .out_last(out_last), .rd_done(rd_done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    logic [15:0] jt_mem [0:2047];
    always @(posedge clk) jt_dout <= jt_mem[jt_rd_addr];

    typedef struct packed {
        logic          busy;
        logic [PN-1:0] grant;
        logic          rd_en;
        logic [13:0]   addr;
        logic          ret_vld;
        logic [10:0]   ret_page;
        logic          out_vld;
        logic [PW-1:0] port;
        logic          out_last;
        logic          done;
        logic          err;
    } obs_t;

    obs_t q[$];
    int   m_rr = 0;
    int   checks = 0, failures = 0, cyc = 0;

    function automatic obs_t sample();
        obs_t a;
        a = {rd_busy, rd_grant, sram_rd_en, sram_rd_addr, np_ret_vld, np_ret_page,
             out_vld, out_port, out_last, rd_done, rd_err};
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected per-cycle script for one packet granted to port w.
    task automatic build(input int w);
        logic [10:0] pg [0:63];
        int P, L, N, err_at;
        logic [15:0] e;
        obs_t c;
        pg[0]  = rd_head_page[w*11 +: 11];
        P      = int'(rd_page_num[w*6 +: 6]);
        if (P == 0) P = 1;
        L      = int'(rd_last_len[w*3 +: 3]);
        err_at = -1;
        for (int j = 0; j < P - 1; j++) begin
            e = jt_mem[pg[j]];
`ifdef SRAM_RD_BANK_CHECK_EN
            if (e[15:11] != BANK) begin
                err_at = 8*j + 2;
                P = j + 1;
                L = 7;
                break;
            end
`endif
            pg[j+1] = e[10:0];
        end
        N = 8*(P-1) + L + 1;
        for (int k = 0; k <= N; k++) begin
            c = '0;
            c.port = PW'(w);
            if (k == 0) c.grant[w] = 1'b1;
            if (k < N) begin
                c.busy  = 1'b1;
                c.rd_en = 1'b1;
                c.addr  = {pg[k/8], 3'(k%8)};
                if (k%8 == 7 || k == N-1) begin
                    c.ret_vld  = 1'b1;
                    c.ret_page = pg[k/8];
                end
            end
            if (k >= 1) c.out_vld = 1'b1;
            if (k == N) begin
                c.out_last = 1'b1;
                c.done     = 1'b1;
            end
            if (k == err_at) c.err = 1'b1;
            q.push_back(c);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin reference: arbitrate only once the previous script has fully played out.
    always @(posedge clk) begin
        if (rst_n && q.size() == 0 && rd_req != '0) begin
            int w;
            w = -1;
            for (int i = 0; i < PN; i++) begin
                int p;
                p = (m_rr + i) % PN;
                if (w < 0 && rd_req[p]) w = p;
            end
            m_rr = (w + 1) % PN;
            build(w);
        end
    end

    always @(negedge clk) begin
        obs_t e, a;
        e = '0;
        if (rst_n && q.size() > 0) e = q.pop_front();
        a = sample();
        if (rst_n) begin
            if (!e.rd_en) a.addr = e.addr;
            if (!e.ret_vld) a.ret_page = e.ret_page;
            if (!(e.busy || e.out_vld)) a.port = e.port;
        end
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL cycle_cmp @%0d got=%h expected=%h", cyc, a, e);
        end
    end

    logic [13:0] addr_log[$];
    logic [10:0] ret_log[$];
    logic [PN-1:0] grant_log[$];
    int gcyc[$], dcyc[$];
    int vld_cnt = 0, last_at = 0, err_cnt = 0;

    always @(negedge clk) begin
        if (sram_rd_en) addr_log.push_back(sram_rd_addr);
        if (np_ret_vld) ret_log.push_back(np_ret_page);
        if (out_vld) vld_cnt++;
        if (out_last) last_at = vld_cnt;
        if (rd_grant != '0) begin
            grant_log.push_back(rd_grant);
            gcyc.push_back(cyc);
        end
        if (rd_done) dcyc.push_back(cyc);
        if (rd_err) err_cnt++;
    end

    task automatic clr_logs();
        addr_log.delete(); ret_log.delete(); grant_log.delete();
        gcyc.delete(); dcyc.delete();
        vld_cnt = 0; last_at = 0; err_cnt = 0;
    endtask

    task automatic set_req(input int p, input logic [10:0] h, input logic [5:0] pn, input logic [2:0] l);
        rd_head_page[p*11 +: 11] = h;
        rd_page_num[p*6 +: 6]    = pn;
        rd_last_len[p*3 +: 3]    = l;
        rd_req[p]                = 1'b1;
    endtask

    task automatic wait_grant(input int p, input int limit);
        int n;
        n = 0;
        while (!rd_grant[p] && n < limit) begin @(negedge clk); n++; end
        if (!rd_grant[p]) begin
            checks++; failures++;
            $display("FAIL grant_timeout port %0d", p);
        end
        rd_req[p] = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!rd_done && n < limit) begin @(negedge clk); n++; end
        if (!rd_done) begin
            checks++; failures++;
            $display("FAIL done_timeout at cycle %0d", cyc);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((rd_busy || q.size() != 0) && n < limit) begin @(negedge clk); n++; end
        if (rd_busy || q.size() != 0) begin
            checks++; failures++;
            $display("FAIL idle_timeout at cycle %0d", cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)
            jt_mem[i] = {(($urandom % 8) == 0) ? 5'($urandom) : BANK, 11'($urandom)};
        jt_mem[11'h010] = {BANK, 11'h055};
        jt_mem[11'h200] = 16'h1C05;
        jt_mem[11'h405] = {BANK, 11'h406};
        repeat (3) @(negedge clk);
        chk("reset_state", int'(sample() != '0), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin from rr_ptr=0 with three continuous requesters.
        clr_logs();
        set_req(0, 11'h100, 6'd1, 3'd3);
        set_req(5, 11'h150, 6'd1, 3'd3);
        set_req(15, 11'h1F0, 6'd1, 3'd3);
        begin
            int n;
            n = 0;
            while (grant_log.size() < 4 && n < 200) begin @(negedge clk); n++; end
        end
        rd_req = '0;
        wait_idle(200);
        chk("rr_count", grant_log.size(), 4);
        chk("rr_g0", int'(grant_log[0]), 16'h0001);
        chk("rr_g1", int'(grant_log[1]), 16'h0020);
        chk("rr_g2", int'(grant_log[2]), 16'h8000);
        chk("rr_g3", int'(grant_log[3]), 16'h0001);
        for (int i = 1; i < 4; i++) chk("rr_gap", gcyc[i] - dcyc[i-1], 1);

        // Two-page packet from port 3.
        clr_logs();
        set_req(3, 11'h010, 6'd2, 3'd2);
        wait_grant(3, 50);
        wait_done(100);
        wait_idle(50);
        chk("single_grant", int'(grant_log[0]), 16'h0008);
        chk("single_nrd", addr_log.size(), 11);
        chk("single_a0", int'(addr_log[0]), 14'h080);
        chk("single_a7", int'(addr_log[7]), 14'h087);
        chk("single_a8", int'(addr_log[8]), 14'h2A8);
        chk("single_a10", int'(addr_log[10]), 14'h2AA);
        chk("single_nret", ret_log.size(), 2);
        chk("single_r0", int'(ret_log[0]), 11'h010);
        chk("single_r1", int'(ret_log[1]), 11'h055);
        chk("single_last", last_at, 11);

        // Single-slice packet.
        clr_logs();
        set_req(9, 11'h7FF, 6'd1, 3'd0);
        wait_grant(9, 50);
        wait_done(20);
        wait_idle(20);
        chk("slice1_nrd", addr_log.size(), 1);
        chk("slice1_addr", int'(addr_log[0]), 14'h3FF8);
        chk("slice1_ret", int'(ret_log[0]), 11'h7FF);
        chk("slice1_done_lat", dcyc[0] - gcyc[0], 1);

        // Page count 0 behaves as one full page.
        clr_logs();
        set_req(2, 11'h123, 6'd0, 3'd7);
        wait_grant(2, 50);
        wait_done(50);
        wait_idle(20);
        chk("pn0_nrd", addr_log.size(), 8);
        chk("pn0_nret", ret_log.size(), 1);
        chk("pn0_ret", int'(ret_log[0]), 11'h123);

        // Head page links into bank 3.
        clr_logs();
        set_req(6, 11'h200, 6'd3, 3'd1);
        wait_grant(6, 50);
        wait_done(100);
        wait_idle(20);
`ifdef SRAM_RD_BANK_CHECK_EN
        chk("bank_err", err_cnt, 1);
        chk("bank_nrd", addr_log.size(), 8);
        chk("bank_nret", ret_log.size(), 1);
        chk("bank_ret", int'(ret_log[0]), 11'h200);
`else
        chk("bank_err", err_cnt, 0);
        chk("bank_nrd", addr_log.size(), 18);
        chk("bank_nret", ret_log.size(), 3);
        chk("bank_ret2", int'(ret_log[2]), 11'h406);
`endif
        chk("bank_done", dcyc.size(), 1);

        // Randomised traffic.
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            for (int p = 0; p < PN; p++) begin
                if (rd_grant[p] && ($urandom % 2 == 0)) rd_req[p] = 1'b0;
                else if (!rd_req[p] && ($urandom % 16 == 0)) begin
                    int r;
                    r = $urandom % 32;
                    set_req(p, 11'($urandom), (r == 0) ? 6'd0 : (r == 1) ? 6'd63 : 6'($urandom_range(1, 4)),
                            3'($urandom));
                end
            end
        end
        rd_req = '0;
        wait_idle(1200);

        // Asynchronous reset in the middle of a packet.
        set_req(7, 11'h300, 6'd3, 3'd5);
        wait_grant(7, 50);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        m_rr = 0;
        #1 chk("async_reset", int'(sample() != '0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr_logs();
        repeat (20) @(negedge clk);
        chk("post_reset_ret", ret_log.size(), 0);
        chk("post_reset_busy", int'(rd_busy), 0);
        chk("post_reset_grant", grant_log.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
